// File: rtl/ppu_pkg.sv
// Shared PPU definitions: register offsets, OAM address widths and the OAMDATAREAD FSM states.
package ppu_pkg;

  localparam logic [7:0] OAMADDL     = 8'h02;
  localparam logic [7:0] OAMADDH     = 8'h03;
  localparam logic [7:0] OAMDATA     = 8'h04;
  localparam logic [7:0] OAMDATAREAD = 8'h38;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned OAM_AW   = 8;
  localparam int unsigned OAMADD_W = 9;
  localparam int unsigned IADDR_W  = 10;
  localparam int unsigned HI_AW    = 5;

  // Byte addresses at or above this point live in the high table, not the RAM
  localparam logic [IADDR_W-1:0] OAM_HI_BASE = 10'h200;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_DONE
  } rd_state_e;

endpackage

// File: rtl/oam_hi_table.sv
// OAM high table: byte register file with one write port and two combinational read ports.
module oam_hi_table
  import ppu_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_we,
  input  logic [HI_AW-1:0]  i_wa,
  input  logic [BYTE_W-1:0] i_wd,
  input  logic [HI_AW-1:0]  i_cpu_ra,
  output logic [BYTE_W-1:0] o_cpu_rd,
  input  logic [HI_AW-1:0]  i_spr_ra,
  output logic [BYTE_W-1:0] o_spr_rd
);

  logic [BYTE_W-1:0] r_mem [DEPTH];

  // Clear all bytes on reset, otherwise a single-byte write per cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_cpu_rd = r_mem[i_cpu_ra];
  assign o_spr_rd = r_mem[i_spr_ra];

endmodule

// File: rtl/oam_cpu_ctrl.sv
// CPU-side OAM access: OAMADD registers, OAMDATA writes with even-byte latching, and OAMDATAREAD sequencing.
module oam_cpu_ctrl
  import ppu_pkg::*;
#(
  parameter bit          BLOCK_RENDER_WR = 1'b1,
  parameter int unsigned HI_BYTES        = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        cpu_addr,
  input  logic [BYTE_W-1:0] cpu_din,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [BYTE_W-1:0] cpu_dout,
  output logic              cpu_rd_valid,
  input  logic              vblank_start,
  input  logic              render_active,
  output logic              ram_cea,
  output logic              ram_wrea,
  output logic [OAM_AW-1:0] ram_ada,
  output logic [WORD_W-1:0] ram_dina,
  input  logic [WORD_W-1:0] ram_douta,
  output logic              prio_rot,
  output logic [6:0]        first_obj,
  input  logic [HI_AW-1:0]  hi_ad,
  output logic [BYTE_W-1:0] hi_dout
);

  rd_state_e             r_state;
  rd_state_e             w_state_nxt;
  logic                  w_rd_issue;
  logic                  w_rd_inc;
  logic                  w_rd_capture;

  logic [OAMADD_W-1:0]   r_oamadd;
  logic [OAMADD_W-1:0]   w_oamadd_nxt;
  logic [IADDR_W-1:0]    r_iaddr;
  logic [BYTE_W-1:0]     r_latch_lo;
  logic                  r_prio_rot;
  logic [6:0]            r_first_obj;

  logic                  r_rd_hi;
  logic                  r_rd_odd;
  logic [HI_AW-1:0]      r_rd_hidx;

  logic                  r_ram_cea;
  logic                  r_ram_wrea;
  logic [OAM_AW-1:0]     r_ram_ada;
  logic [WORD_W-1:0]     r_ram_dina;
  logic [BYTE_W-1:0]     r_cpu_dout;
  logic                  r_cpu_rd_valid;

  logic                  w_idle;
  logic                  w_blocked;
  logic                  w_wr_addl;
  logic                  w_wr_addh;
  logic                  w_wr_data_any;
  logic                  w_wr_data;
  logic                  w_iaddr_hi;
  logic                  w_commit;
  logic                  w_latch;
  logic                  w_hi_we;
  logic [BYTE_W-1:0]     w_hi_cpu;

  // Access decode; writes are only honoured while the read FSM is idle
  assign w_idle        = (r_state == IDLE);
  assign w_blocked     = BLOCK_RENDER_WR && render_active;
  assign w_wr_addl     = w_idle && cpu_wr && (cpu_addr == OAMADDL);
  assign w_wr_addh     = w_idle && cpu_wr && (cpu_addr == OAMADDH);
  assign w_wr_data_any = w_idle && cpu_wr && (cpu_addr == OAMDATA);
  assign w_wr_data     = w_wr_data_any && !w_blocked;
  assign w_iaddr_hi    = (r_iaddr >= OAM_HI_BASE);
  assign w_commit      = w_wr_data && !w_iaddr_hi && r_iaddr[0];
  assign w_latch       = w_wr_data && !w_iaddr_hi && !r_iaddr[0];
  assign w_hi_we       = w_wr_data && w_iaddr_hi;

  // New OAMADD value so a coincident vblank reload sees the freshly written address
  always_comb begin
    w_oamadd_nxt = r_oamadd;
    if (w_wr_addl) w_oamadd_nxt[7:0] = cpu_din;
    if (w_wr_addh) w_oamadd_nxt[8]   = cpu_din[0];
  end

  // Read FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Read FSM next state and per-state strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_rd_issue   = 1'b0;
    w_rd_inc     = 1'b0;
    w_rd_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_rd && (cpu_addr == OAMDATAREAD)) begin
          w_rd_issue  = 1'b1;
          w_state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        w_rd_inc    = 1'b1;
        w_state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        w_rd_capture = 1'b1;
        w_state_nxt  = RD_DONE;
      end
      RD_DONE:  w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Address registers, even-byte latch and the captured read location
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_oamadd    <= '0;
      r_first_obj <= '0;
      r_prio_rot  <= 1'b0;
      r_iaddr     <= '0;
      r_latch_lo  <= '0;
      r_rd_hi     <= 1'b0;
      r_rd_odd    <= 1'b0;
      r_rd_hidx   <= '0;
    end else begin
      r_oamadd    <= w_oamadd_nxt;
      r_first_obj <= w_oamadd_nxt[7:1];
      if (w_wr_addh) r_prio_rot <= cpu_din[7];
      if (w_wr_addl || w_wr_addh || vblank_start) begin
        r_iaddr <= {w_oamadd_nxt, 1'b0};
      end else if (w_wr_data_any || w_rd_inc) begin
        r_iaddr <= r_iaddr + IADDR_W'(1);
      end
      if (w_latch) r_latch_lo <= cpu_din;
      if (w_rd_issue) begin
        r_rd_hi   <= w_iaddr_hi;
        r_rd_odd  <= r_iaddr[0];
        r_rd_hidx <= r_iaddr[HI_AW-1:0];
      end
    end
  end

  // OAM port A: one-cycle strobes for odd-byte commits and read issues
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ram_cea  <= 1'b0;
      r_ram_wrea <= 1'b0;
      r_ram_ada  <= '0;
      r_ram_dina <= '0;
    end else begin
      r_ram_cea  <= w_commit || w_rd_issue;
      r_ram_wrea <= w_commit;
      if (w_commit || w_rd_issue) r_ram_ada <= r_iaddr[OAM_AW:1];
      if (w_commit)               r_ram_dina <= {cpu_din, r_latch_lo};
    end
  end

  // Read data capture and valid pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cpu_dout     <= '0;
      r_cpu_rd_valid <= 1'b0;
    end else begin
      r_cpu_rd_valid <= w_rd_capture;
      if (w_rd_capture) begin
        r_cpu_dout <= r_rd_hi  ? w_hi_cpu :
                      r_rd_odd ? ram_douta[15:8] : ram_douta[7:0];
      end
    end
  end

  oam_hi_table #(
    .DEPTH (HI_BYTES)
  ) u_hi_table (
    .clk      (clk),
    .resetn   (resetn),
    .i_we     (w_hi_we),
    .i_wa     (r_iaddr[HI_AW-1:0]),
    .i_wd     (cpu_din),
    .i_cpu_ra (r_rd_hidx),
    .o_cpu_rd (w_hi_cpu),
    .i_spr_ra (hi_ad),
    .o_spr_rd (hi_dout)
  );

  assign cpu_dout     = r_cpu_dout;
  assign cpu_rd_valid = r_cpu_rd_valid;
  assign ram_cea      = r_ram_cea;
  assign ram_wrea     = r_ram_wrea;
  assign ram_ada      = r_ram_ada;
  assign ram_dina     = r_ram_dina;
  assign prio_rot     = r_prio_rot;
  assign first_obj    = r_first_obj;

endmodule

// File: tb/tb_oam_cpu_ctrl.sv
// Bench for oam_cpu_ctrl: directed scenarios followed by random register traffic against a byte-level OAM model.
module tb_oam_cpu_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  cpu_dout;
  logic        cpu_rd_valid;
  logic        vblank_start;
  logic        render_active;
  logic        ram_cea;
  logic        ram_wrea;
  logic [7:0]  ram_ada;
  logic [15:0] ram_dina;
  logic [15:0] ram_douta;
  logic        prio_rot;
  logic [6:0]  first_obj;
  logic [4:0]  hi_ad;
  logic [7:0]  hi_dout;

  always #5 clk = ~clk;

  oam_cpu_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .cpu_addr      (cpu_addr),
    .cpu_din       (cpu_din),
    .cpu_wr        (cpu_wr),
    .cpu_rd        (cpu_rd),
    .cpu_dout      (cpu_dout),
    .cpu_rd_valid  (cpu_rd_valid),
    .vblank_start  (vblank_start),
    .render_active (render_active),
    .ram_cea       (ram_cea),
    .ram_wrea      (ram_wrea),
    .ram_ada       (ram_ada),
    .ram_dina      (ram_dina),
    .ram_douta     (ram_douta),
    .prio_rot      (prio_rot),
    .first_obj     (first_obj),
    .hi_ad         (hi_ad),
    .hi_dout       (hi_dout)
  );

  // 256x16 OAM block RAM fixture with a backdoor load port
  logic [15:0] fx_mem [256];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [15:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) begin
      fx_mem[bd_addr] <= bd_data;
    end else if (ram_cea) begin
      if (ram_wrea) fx_mem[ram_ada] <= ram_dina;
      ram_douta <= fx_mem[ram_ada];
    end
  end

  // Reference model: byte-addressed OAM view
  logic [15:0] m_mem [256];
  logic [7:0]  m_hi [32];
  int          m_oamadd;
  int          m_iaddr;
  logic [7:0]  m_latch;
  logic [7:0]  m_dout;
  logic        m_prio;

  int          n_vec;
  int          n_err;
  int          n_cea;
  int          n_wrea;
  int          n_valid;
  logic [7:0]  last_ada;
  logic [15:0] last_dina;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and tally port activity seen there
  task automatic tick();
    @(negedge clk);
    if (ram_cea === 1'b1) n_cea++;
    if (ram_wrea === 1'b1) begin
      n_wrea++;
      last_ada  = ram_ada;
      last_dina = ram_dina;
    end
    if (cpu_rd_valid === 1'b1) n_valid++;
  endtask

  task automatic check_hi(input int idx);
    hi_ad = 5'(idx);
    #1;
    check("hi_dout", {24'h0, hi_dout}, {24'h0, m_hi[idx]});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_hi[i] = 8'h00;
    m_oamadd = 0;
    m_iaddr  = 0;
    m_latch  = 8'h00;
    m_dout   = 8'h00;
    m_prio   = 1'b0;
  endtask

  task automatic do_wr(input logic [7:0] a, input logic [7:0] d, input bit vb, input bit rnd);
    int c0, w0, v0, exp_wr, word, hidx;
    c0 = n_cea; w0 = n_wrea; v0 = n_valid;
    exp_wr = 0; word = -1; hidx = -1;
    case (a)
      8'h02: begin
        m_oamadd = (m_oamadd & 'h100) | int'(d);
        m_iaddr  = 2 * m_oamadd;
      end
      8'h03: begin
        m_oamadd = (m_oamadd & 'hFF) | (int'(d[0]) << 8);
        m_prio   = d[7];
        m_iaddr  = 2 * m_oamadd;
      end
      8'h04: begin
        if (!rnd) begin
          if (m_iaddr >= 512) begin
            hidx = m_iaddr % 32;
            m_hi[hidx] = d;
          end else if (m_iaddr % 2 == 0) begin
            m_latch = d;
          end else begin
            word = m_iaddr / 2;
            m_mem[word] = {d, m_latch};
            exp_wr = 1;
          end
        end
        m_iaddr = (m_iaddr + 1) % 1024;
      end
      default: ;
    endcase
    if (vb) m_iaddr = 2 * m_oamadd;

    cpu_addr = a; cpu_din = d; cpu_wr = 1'b1; vblank_start = vb; render_active = rnd;
    tick();
    cpu_wr = 1'b0; vblank_start = 1'b0; render_active = 1'b0;
    repeat (3) tick();

    check("wr_wrea_pulses", n_wrea - w0, exp_wr);
    check("wr_cea_pulses", n_cea - c0, exp_wr);
    check("wr_no_valid", n_valid - v0, 0);
    check("prio_rot", {31'h0, prio_rot}, {31'h0, m_prio});
    check("first_obj", {25'h0, first_obj}, (m_oamadd >> 1) & 127);
    if (word >= 0) begin
      check("ram_ada", {24'h0, last_ada}, word);
      check("ram_dina", {16'h0, last_dina}, {16'h0, m_mem[word]});
      check("ram_word", {16'h0, fx_mem[word]}, {16'h0, m_mem[word]});
    end
    if (hidx >= 0) check_hi(hidx);
    else           check_hi(int'($urandom_range(0, 31)));
  endtask

  task automatic do_rd(input logic [7:0] a);
    int c0, w0, v0, lat;
    logic [15:0] wd;
    logic [7:0]  exp_b;
    c0 = n_cea; w0 = n_wrea; v0 = n_valid; lat = 0;
    exp_b = m_dout;
    if (a == 8'h38) begin
      if (m_iaddr >= 512) begin
        exp_b = m_hi[m_iaddr % 32];
      end else begin
        wd    = m_mem[m_iaddr / 2];
        exp_b = (m_iaddr % 2 == 1) ? wd[15:8] : wd[7:0];
      end
      m_iaddr = (m_iaddr + 1) % 1024;
      m_dout  = exp_b;
    end

    cpu_addr = a; cpu_rd = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) cpu_rd = 1'b0;
      if (cpu_rd_valid === 1'b1 && lat == 0) lat = k;
    end

    if (a == 8'h38) begin
      check("rd_latency", lat, 3);
      check("rd_valid_pulses", n_valid - v0, 1);
      check("rd_cea_pulses", n_cea - c0, 1);
    end else begin
      check("rd_ignored_valid", n_valid - v0, 0);
      check("rd_ignored_cea", n_cea - c0, 0);
    end
    check("rd_no_wrea", n_wrea - w0, 0);
    check("cpu_dout", {24'h0, cpu_dout}, {24'h0, exp_b});
  endtask

  task automatic do_vblank();
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
    repeat (3) tick();
    m_iaddr = 2 * m_oamadd;
  endtask

  initial begin
    int v0;
    n_vec = 0; n_err = 0; n_cea = 0; n_wrea = 0; n_valid = 0;
    last_ada = '0; last_dina = '0;
    resetn = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    vblank_start = 1'b0; render_active = 1'b0; hi_ad = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    model_reset();

    // Fill the RAM with random words while held in reset
    for (int i = 0; i < 256; i++) begin
      bd_we = 1'b1; bd_addr = 8'(i); bd_data = 16'($urandom);
      m_mem[i] = bd_data;
      tick();
    end
    bd_we = 1'b0;

    // Reset state
    check("rst_cpu_dout", {24'h0, cpu_dout}, 32'h0);
    check("rst_rd_valid", {31'h0, cpu_rd_valid}, 32'h0);
    check("rst_prio_rot", {31'h0, prio_rot}, 32'h0);
    check("rst_first_obj", {25'h0, first_obj}, 32'h0);
    check("rst_ram_cea", {31'h0, ram_cea}, 32'h0);
    check("rst_ram_wrea", {31'h0, ram_wrea}, 32'h0);
    check("rst_ram_ada", {24'h0, ram_ada}, 32'h0);
    check("rst_ram_dina", {16'h0, ram_dina}, 32'h0);
    check_hi(0);
    check_hi(31);
    resetn = 1'b1;
    tick();

    // Even/odd pair commits one word; iaddr lands on 0x022
    do_wr(8'h02, 8'h10, 1'b0, 1'b0);
    do_wr(8'h03, 8'h00, 1'b0, 1'b0);
    do_wr(8'h04, 8'hAA, 1'b0, 1'b0);
    do_wr(8'h04, 8'hBB, 1'b0, 1'b0);
    check("t1_ada", {24'h0, last_ada}, 32'h10);
    check("t1_dina", {16'h0, last_dina}, 32'hBBAA);
    do_rd(8'h38);

    // High-table write with priority rotation
    do_wr(8'h03, 8'h81, 1'b0, 1'b0);
    do_wr(8'h02, 8'h00, 1'b0, 1'b0);
    do_wr(8'h04, 8'h5C, 1'b0, 1'b0);
    hi_ad = 5'd0; #1;
    check("t2_hi0", {24'h0, hi_dout}, 32'h5C);
    check("t2_prio", {31'h0, prio_rot}, 32'h1);
    check("t2_first_obj", {25'h0, first_obj}, 32'h0);

    // Two reads of a known word
    bd_we = 1'b1; bd_addr = 8'h20; bd_data = 16'h1234;
    m_mem[32] = 16'h1234;
    tick();
    bd_we = 1'b0;
    do_wr(8'h03, 8'h00, 1'b0, 1'b0);
    do_wr(8'h02, 8'h20, 1'b0, 1'b0);
    do_rd(8'h38);
    check("t3_lo", {24'h0, cpu_dout}, 32'h34);
    do_rd(8'h38);
    check("t3_hi", {24'h0, cpu_dout}, 32'h12);

    // Byte address wraps from the top of the high table
    do_wr(8'h03, 8'h01, 1'b0, 1'b0);
    do_wr(8'h02, 8'hFF, 1'b0, 1'b0);
    do_wr(8'h04, 8'h11, 1'b0, 1'b0);
    do_wr(8'h04, 8'h22, 1'b0, 1'b0);
    hi_ad = 5'd31; #1;
    check("t4_hi1f", {24'h0, hi_dout}, 32'h22);
    do_rd(8'h38);

    // Writes dropped during rendering still advance the address
    do_wr(8'h03, 8'h00, 1'b0, 1'b0);
    do_wr(8'h02, 8'h30, 1'b0, 1'b0);
    do_wr(8'h04, 8'h66, 1'b0, 1'b1);
    do_wr(8'h04, 8'h77, 1'b0, 1'b1);
    do_rd(8'h38);

    // Commit coincident with vblank reload
    do_wr(8'h02, 8'h40, 1'b0, 1'b0);
    do_wr(8'h04, 8'hA1, 1'b0, 1'b0);
    do_wr(8'h04, 8'hB2, 1'b1, 1'b0);
    do_rd(8'h38);
    check("t6_reload_rd", {24'h0, cpu_dout}, 32'hA1);

    // Ignored addresses
    do_rd(8'h39);
    do_wr(8'h05, 8'hEE, 1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      int op;
      logic [7:0] a;
      op = int'($urandom_range(0, 9));
      case (op)
        0: do_wr(8'h02, 8'($urandom), $urandom_range(0, 7) == 0, 1'b0);
        1: do_wr(8'h03, 8'($urandom), $urandom_range(0, 7) == 0, 1'b0);
        2, 3, 4: do_wr(8'h04, 8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
        5, 6: do_rd(8'h38);
        7: begin
          a = 8'($urandom);
          if (a == 8'h38) a = 8'h37;
          do_rd(a);
        end
        8: begin
          a = 8'($urandom);
          if (a >= 8'h02 && a <= 8'h04) a = 8'h06;
          do_wr(a, 8'($urandom), 1'b0, 1'b0);
        end
        default: do_vblank();
      endcase
    end

    // Reset in the middle of a read
    v0 = n_valid;
    cpu_addr = 8'h38; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    repeat (4) tick();
    model_reset();
    check("rstrd_no_valid", n_valid - v0, 0);
    check("rstrd_cpu_dout", {24'h0, cpu_dout}, 32'h0);
    check("rstrd_ram_cea", {31'h0, ram_cea}, 32'h0);
    check("rstrd_first_obj", {25'h0, first_obj}, 32'h0);
    check_hi(int'($urandom_range(0, 31)));
    do_rd(8'h38);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/oam_cpu_ctrl.md
Name: oam_cpu_ctrl

Overview:
CPU-side access controller for the sprite attribute memory (OAM).
- Implements the PPU registers $2102/$2103 (OAMADDL/H), $2104 (OAMDATA write) and $2138 (OAMDATAREAD).
- Sequences port A of the 256x16 OAM block RAM, including even-byte latching for 16-bit commits.
- Holds the 32-byte high table in local registers.
- Exports the priority-rotation start sprite and a high-table read port to the sprite fetch engine.

Parameters:
- BLOCK_RENDER_WR, 1: when 1, $2104 writes during render_active are dropped; the address still increments.
- HI_BYTES, 32: high-table size in bytes. Fixed by hardware; do not override.

Ports:
- clk  in  1  system clock, also clocks OAM port A.
- resetn  in  1  asynchronous, active-low reset.
- cpu_addr  in  8  low byte of the $21xx register address.
- cpu_din  in  8  CPU write data.
- cpu_wr  in  1  one-cycle write strobe.
- cpu_rd  in  1  one-cycle read strobe.
- cpu_dout  out  8  read data, held until the next read.
- cpu_rd_valid  out  1  one-cycle pulse when cpu_dout is updated.
- vblank_start  in  1  one-cycle pulse at the start of vblank.
- render_active  in  1  high while the PPU is rendering (not forced blank, not vblank).
- ram_cea  out  1  OAM port A clock enable.
- ram_wrea  out  1  OAM port A write enable.
- ram_ada  out  8  OAM port A word address.
- ram_dina  out  16  OAM port A write data.
- ram_douta  in  16  OAM port A read data, valid 1 clk after ram_cea.
- prio_rot  out  1  OAMADDH bit 7.
- first_obj  out  7  priority-rotation first sprite index.
- hi_ad  in  5  high-table read address from the sprite engine.
- hi_dout  out  8  high-table byte, combinational read.

Behaviour:
- Reset values:
  - oamadd, iaddr, latch_lo, cpu_dout, prio_rot, first_obj and all ram_* outputs are 0.
  - Every high-table byte is 0.
  - FSM state is IDLE.
- Registers:
  - oamadd is 9 bits (word address). $2102 writes oamadd[7:0]. $2103 writes oamadd[8] from bit 0 and prio_rot from bit 7.
  - first_obj = oamadd[7:1], registered.
- Internal byte address iaddr is 10 bits.
  - Reloaded to {oamadd,1'b0} on any $2102/$2103 write and on vblank_start.
  - Increments by 1 after every $2104 write and every $2138 read.
  - Wraps 0x3FF -> 0x000.
- $2104 write, iaddr[9]=0, iaddr[0]=0: latch_lo <= cpu_din. No RAM access.
- $2104 write, iaddr[9]=0, iaddr[0]=1: on the next clk, drive ram_cea=1, ram_wrea=1, ram_ada=iaddr[8:1] and ram_dina={cpu_din,latch_lo} for exactly one cycle.
- $2104 write, iaddr[9]=1: high[iaddr[4:0]] <= cpu_din immediately. latch_lo is unchanged.
- Write blocking: with BLOCK_RENDER_WR=1 and render_active=1, a $2104 write changes neither the RAM, the high table nor latch_lo, but iaddr still increments.
- $2138 read FSM:
  - IDLE, on cpu_rd with cpu_addr=0x38 -> RD_ISSUE.
  - RD_ISSUE: ram_cea=1, ram_wrea=0, ram_ada=iaddr[8:1]; iaddr increments. -> RD_WAIT.
  - RD_WAIT: capture the byte. Source is ram_douta[7:0] if the captured iaddr[0]=0, ram_douta[15:8] if 1, or high[addr[4:0]] if addr[9]=1. -> RD_DONE.
  - RD_DONE: cpu_dout updated, cpu_rd_valid=1. -> IDLE.
  - Total latency: cpu_rd_valid is exactly 3 clks after cpu_rd, for both RAM and high-table reads.
- Busy handling: cpu_wr and cpu_rd are ignored while the FSM is not IDLE. Callers space accesses >= 4 clks.
- Reads of other addresses: cpu_rd on any address other than 0x38 is ignored (no cpu_rd_valid).
- Writes of other addresses: cpu_wr on addresses other than 0x02/0x03/0x04 is ignored.
- Simultaneous events:
  - $2102/$2103 write in the same cycle as vblank_start: the register updates first, and the reload uses the new oamadd.
  - $2104 write in the same cycle as vblank_start: the write uses the old iaddr, then iaddr = {oamadd,0} (reload wins over increment).
- Reset mid-read: the FSM returns to IDLE and no cpu_rd_valid is emitted.
- ram_cea and ram_wrea are never asserted outside the cycles defined above.

Decomposition:
- Shared package ppu_pkg holds:
  - register offsets: OAMADDL=8'h02, OAMADDH=8'h03, OAMDATA=8'h04, OAMDATAREAD=8'h38;
  - the read FSM state enum {IDLE, RD_ISSUE, RD_WAIT, RD_DONE};
  - the OAM_HI_BASE=10'h200 constant.
- One sub-module, oam_hi_table: 32x8 register file with a synchronous write port, a combinational CPU read port and a combinational sprite-engine read port.
- Address and FSM logic stay in the top module.

Test Plan:
- Write $2102=0x10, $2103=0x00, then $2104=0xAA, $2104=0xBB -> exactly one ram_wrea pulse, with ada=0x10 and dina=0xBBAA; iaddr=0x022.
- Write $2103=0x81, $2102=0x00, then $2104=0x5C -> high[0]=0x5C, no ram_cea, prio_rot=1, first_obj=0x00.
- Preload RAM word 0x20=0x1234, set oamadd=0x020, read $2138 twice -> cpu_dout 0x34 then 0x12, each cpu_rd_valid 3 clks after its cpu_rd.
- Set iaddr=0x3FF and write $2104 -> high[0x1F] written, iaddr wraps to 0x000.
- BLOCK_RENDER_WR=1, render_active=1, odd-byte $2104 write -> no ram_wrea, iaddr still increments.
- $2104 write coincident with vblank_start while oamadd=0x040 -> write lands at the old address, then iaddr=0x080.
